serial_word_feeder: RTL

//  Upstream feeder for the serial pattern detector: accepts parallel words over a

---
 rtl/ser_pkg.sv | 17 +
 rtl/word_hold_reg.sv | 44 ++++
 rtl/serial_word_feeder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial word feeder.
//   ST_IDLE / ST_SHIFT : FSM state encodings
//   IDLE_BIT_DEFAULT   : default line level on x while no bit is valid
//   state_e            : typed FSM state built from the encodings above
package ser_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam bit IDLE_BIT_DEFAULT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

endpackage

// File: rtl/word_hold_reg.sv
// One-entry holding buffer: a Width-bit data register plus a full flag.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset (empties the buffer)
//   load_i  : capture data_i and mark full
//   take_i  : mark empty (data consumed by the shifter)
//   data_i  : word to capture
//   data_o  : stored word
//   full_o  : buffer holds an unconsumed word
module word_hold_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             take_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o
);

  logic [Width-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
      end
      // load and take are mutually exclusive at the top level; load wins if not.
      if (load_i) begin
        full_q <= 1'b1;
      end else if (take_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/serial_word_feeder.sv
// Accepts parallel words over valid/ready and shifts them out one bit per clock on x.
// A one-entry holding buffer lets the next word load on the same edge the last bit ends.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   din       : parallel word, sampled on accept (din_valid & din_ready)
//   din_valid : din carries a word
//   din_ready : holding buffer empty
//   x         : serial bit (registered), IDLE_BIT when not valid
//   x_valid   : x carries a data bit (registered)
//   busy      : shifter active or buffer full
module serial_word_feeder
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CntW-1:0]  cnt_q;
  logic             x_q;
  logic             x_valid_q;

  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic             accept;
  logic             take;

  logic             buf_first;
  logic [WIDTH-1:0] buf_rest;
  logic             sh_next;
  logic [WIDTH-1:0] sh_rest;

  assign din_ready = ~buf_full;
  assign accept    = din_valid & ~buf_full;
  // Drain the buffer when idle, or when the last bit of the current word is on x.
  assign take      = buf_full & ((state_q == StIdle) || (cnt_q == '0));

  word_hold_reg #(
    .Width (WIDTH)
  ) u_hold (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (accept),
    .take_i (take),
    .data_i (din),
    .data_o (buf_data),
    .full_o (buf_full)
  );

  // The shifter holds the not-yet-sent bits aligned so the next one is always at the
  // send end (MSB for MSB_FIRST, LSB otherwise).
  always_comb begin
    if (MSB_FIRST) begin
      buf_first = buf_data[WIDTH-1];
      buf_rest  = {buf_data[WIDTH-2:0], 1'b0};
      sh_next   = sh_q[WIDTH-1];
      sh_rest   = {sh_q[WIDTH-2:0], 1'b0};
    end else begin
      buf_first = buf_data[0];
      buf_rest  = {1'b0, buf_data[WIDTH-1:1]};
      sh_next   = sh_q[0];
      sh_rest   = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sh_q      <= '0;
      cnt_q     <= '0;
      x_q       <= IDLE_BIT;
      x_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (buf_full) begin
            sh_q      <= buf_rest;
            cnt_q     <= CntLast;
            x_q       <= buf_first;
            x_valid_q <= 1'b1;
            state_q   <= StShift;
          end else begin
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
          end
        end
        StShift: begin
          if (cnt_q != '0) begin
            sh_q  <= sh_rest;
            cnt_q <= cnt_q - 1'b1;
            x_q   <= sh_next;
          end else if (buf_full) begin
            sh_q      <= buf_rest;
            cnt_q     <= CntLast;
            x_q       <= buf_first;
            x_valid_q <= 1'b1;
          end else begin
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
      endcase
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = (state_q == StShift) | buf_full;

endmodule
